button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 500000, meaning the number of consecutive stable synchronized samples needed to accept a level change (10 ms at 50 MHz); its legal range SHALL be 2 to 2^20-1.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 50000000, meaning the number of cycles the accepted level must stay high before a long press is reported (1 s at 50 MHz); its legal range SHALL be 2 to 2^26-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock (PLL output); all logic SHALL be in this domain.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port btn_in, input, 1 bit: raw, asynchronous, bouncing push-button level, where 1 means pressed.
REQ-006 The block SHALL have port btn_level, output, 1 bit: registered debounced level, consumed by the downstream reset-enable stage.
REQ-007 The block SHALL have port btn_rise, output, 1 bit: one-cycle pulse on each accepted 0->1 transition.
REQ-008 The block SHALL have port btn_fall, output, 1 bit: one-cycle pulse on each accepted 1->0 transition.
REQ-009 The block SHALL have port btn_long, output, 1 bit: one-cycle long-press pulse; this port SHALL always be present (see Configuration).

Function
REQ-010 btn_in SHALL pass through a 2-flop synchronizer (sync0 -> sync1); only sync1 SHALL feed the FSM.
REQ-011 The FSM SHALL have exactly four states: LOW, RISE_CHK, HIGH, FALL_CHK.
REQ-012 In LOW, when sync1=1 the FSM SHALL go to RISE_CHK and clear the 20-bit stable counter cnt to 0.
REQ-013 In RISE_CHK:
- when sync1=0, the FSM SHALL return to LOW with no output pulse (bounce rejected);
- otherwise cnt SHALL increment;
- when sync1=1 and cnt==STABLE_CYCLES-1, the FSM SHALL go to HIGH, set btn_level=1, and pulse btn_rise for one cycle.
REQ-014 In HIGH, when sync1=0 the FSM SHALL go to FALL_CHK and clear cnt to 0.
REQ-015 In FALL_CHK:
- when sync1=1, the FSM SHALL return to HIGH with no pulse;
- otherwise cnt SHALL increment;
- when sync1=0 and cnt==STABLE_CYCLES-1, the FSM SHALL go to LOW, clear btn_level, and pulse btn_fall.
REQ-016 Latency: for a clean step on btn_in, btn_rise/btn_fall and the btn_level change SHALL become visible exactly STABLE_CYCLES+3 clock edges after the first edge that samples the new btn_in value.
REQ-017 btn_rise, btn_fall and btn_long SHALL each be high for exactly one cycle per event and SHALL never be high simultaneously.
REQ-018 btn_level SHALL change only on the cycles in which btn_rise or btn_fall is asserted.
REQ-019 cnt SHALL never wrap: every path that increments it SHALL leave its state at or before STABLE_CYCLES-1.
REQ-020 A sync1 glitch lasting fewer than STABLE_CYCLES cycles SHALL produce no output change.

Reset
REQ-021 When reset=1 at a clk edge, the block SHALL load: state=LOW, sync0=sync1=0, cnt=0, hold_cnt=0, btn_level=0, btn_rise=0, btn_fall=0, btn_long=0.
REQ-022 reset SHALL take priority over every other event in the same cycle, including a pending qualification.
REQ-023 Reset asserted mid-qualification SHALL abandon the qualification with no pulse issued.
REQ-024 If btn_in is held at 1 through reset release, the block SHALL qualify it normally and issue btn_rise STABLE_CYCLES+3 edges after the first edge with reset=0.

Configuration
REQ-025 With macro BTN_LONG_PRESS_EN defined:
- a 26-bit hold_cnt SHALL increment every cycle in HIGH and FALL_CHK;
- when hold_cnt==HOLD_CYCLES-1, btn_long SHALL pulse once and hold_cnt SHALL saturate, with no repeat until LOW is re-entered;
- hold_cnt SHALL clear on entry to LOW;
- a bounce FALL_CHK->HIGH SHALL NOT clear hold_cnt.
REQ-026 Without BTN_LONG_PRESS_EN, hold_cnt logic SHALL be absent, btn_long SHALL be tied to constant 0, and all other behaviour SHALL be unchanged.

Verification (STABLE_CYCLES=4, HOLD_CYCLES=10)
REQ-027 Clean press: reset, then btn_in 0->1 held -> btn_rise=1 for one cycle and btn_level=1 on edge 7 after the first sampling edge, with btn_fall=0 throughout.
REQ-028 Bounce rejection: btn_in pattern 1,0,1,1,0,1 (one per cycle), then 0 held -> btn_level stays 0 and no pulse of any kind occurs.
REQ-029 Clean release after press: btn_in 1->0 held -> btn_fall for one cycle on edge 7, btn_level=0 at the same time.
REQ-030 Reset mid-qualification: btn_in=1; assert reset for one cycle at edge 5; keep btn_in=1 -> no pulse before reset, then btn_rise at edge 7 counted from the first edge after reset release.
REQ-031 Long press (macro defined): hold btn_in=1 for 30 cycles -> exactly one btn_long pulse, 10 edges after the btn_rise edge; with the macro undefined, btn_long stays 0.
REQ-032 Release bounce during hold (macro defined): while HIGH with hold_cnt=5, a 2-cycle btn_in=0 glitch -> no btn_fall, and btn_long still fires at hold_cnt==9.

Source files
------------

// File: rtl/button_debounce.sv
// Push-button debouncer: two-flop synchronizer followed by a four-state
// qualification FSM that accepts a level change only after STABLE_CYCLES
// consecutive agreeing samples. It emits a registered level and one-cycle
// rise/fall pulses.
// Optional long-press detector: define BTN_LONG_PRESS_EN to enable it. When
// enabled, btn_long pulses once after the accepted level has been high for
// HOLD_CYCLES cycles. Without the macro, btn_long is tied to 0.
module button_debounce #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES   = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_long
);

  localparam logic [1:0] ST_LOW      = 2'd0;
  localparam logic [1:0] ST_RISE_CHK = 2'd1;
  localparam logic [1:0] ST_HIGH     = 2'd2;
  localparam logic [1:0] ST_FALL_CHK = 2'd3;

  localparam logic [19:0] STABLE_LAST = 20'(STABLE_CYCLES - 1);

  // Reject out-of-range configurations at elaboration time.
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 32'h000F_FFFF ||
      HOLD_CYCLES < 2 || HOLD_CYCLES > 32'h03FF_FFFF) begin : g_bad_params
    $error("button_debounce: STABLE_CYCLES or HOLD_CYCLES out of range");
  end

  logic        sync0_q, sync0_d;
  logic        sync1_q, sync1_d;
  logic [1:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        rise_q, rise_d;
  logic        fall_q, fall_d;

  // Next-state logic for the synchronizer and the qualification FSM.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave a
    // value unassigned and infer a latch.
    sync0_d = btn_in;
    sync1_d = sync0_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (sync1_q) begin
          state_d = ST_RISE_CHK;
          cnt_d   = '0;
        end
      end
      ST_RISE_CHK: begin
        if (!sync1_q) begin
          state_d = ST_LOW;
        end else if (cnt_q == STABLE_LAST) begin
          // The counter holds here rather than wrapping.
          state_d = ST_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      ST_HIGH: begin
        if (!sync1_q) begin
          state_d = ST_FALL_CHK;
          cnt_d   = '0;
        end
      end
      ST_FALL_CHK: begin
        if (sync1_q) begin
          state_d = ST_HIGH;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  // State registers; reset overrides any pending qualification.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYCLES - 1);
  localparam logic [25:0] HOLD_SAT  = 26'(HOLD_CYCLES);

  logic [25:0] hold_q, hold_d;
  logic        long_q, long_d;

  // Hold timer: runs while the accepted level is high, survives release
  // bounces, parks one past the trigger value, and clears on return to LOW.
  // A release accepted on the trigger cycle suppresses the long pulse.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_d == ST_LOW) begin
      hold_d = '0;
    end else if (state_q == ST_HIGH || state_q == ST_FALL_CHK) begin
      if (hold_q != HOLD_SAT) begin
        hold_d = hold_q + 26'd1;
      end
      long_d = (hold_q == HOLD_LAST);
    end
  end

  // Hold timer and long-press pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign btn_long = long_q;
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (STABLE_CYCLES=4, HOLD_CYCLES=10).
// The reference model states the acceptance rule directly:
// a level flips after STABLE_CYCLES+1 consecutive synchronized samples that
// disagree with it. A long press fires HOLD_CYCLES edges after the rise,
// provided the level is still high.
module tb_button_debounce;

  localparam int S = 4;
  localparam int H = 10;
`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, btn_rise, btn_fall, btn_long;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_debounce #(.STABLE_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall),
    .btn_long (btn_long)
  );

  // Reference model state.
  logic hist[$];
  bit   m_level;
  int   m_run;
  int   m_age;
  bit   e_rise, e_fall, e_long;

  // Drive one cycle of stimulus, then advance the model across the edge.
  // Outputs are valid for comparison 1 ns after the edge.
  task automatic step(input logic b, input logic r);
    logic smp;
    bit   was;
    @(negedge clk);
    btn_in = b;
    reset  = r;
    @(posedge clk);
    e_rise = 1'b0;
    e_fall = 1'b0;
    e_long = 1'b0;
    if (r) begin
      hist.delete();
      m_level = 1'b0;
      m_run   = 0;
      m_age   = 0;
    end else begin
      hist.push_back(b);
      if (hist.size() > 3) void'(hist.pop_front());
      smp = (hist.size() == 3) ? hist[0] : 1'b0;
      was = m_level;
      if (smp != m_level) begin
        m_run++;
        if (m_run == S + 1) begin
          m_level = smp;
          m_run   = 0;
          e_rise  = smp;
          e_fall  = !smp;
        end
      end else begin
        m_run = 0;
      end
      if (was && m_level) begin
        m_age++;
        e_long = LONG_EN && (m_age == H);
      end else begin
        m_age = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(1)), 1'b1);
      checks++;
      if ({btn_level, btn_rise, btn_fall, btn_long} !== 4'b0000) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b exp=0000", i,
                 {btn_level, btn_rise, btn_fall, btn_long});
      end
    end
  endtask

  task automatic test_clean_press();
    int rise_edge = -1;
    int rise_cnt = 0;
    int fall_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if ({btn_level, btn_rise, btn_fall, btn_long} !== {m_level, e_rise, e_fall, e_long}) begin
        failures++;
        $display("FAIL clean_press edge=%0d got=%b exp=%b", i,
                 {btn_level, btn_rise, btn_fall, btn_long}, {m_level, e_rise, e_fall, e_long});
      end
      if (btn_rise) begin rise_edge = i; rise_cnt++; end
      if (btn_fall) fall_cnt++;
    end
    checks++;
    if (rise_edge != S + 3 || rise_cnt != 1 || fall_cnt != 0) begin
      failures++;
      $display("FAIL clean_press_latency rise_edge=%0d rises=%0d falls=%0d exp edge=%0d rises=1 falls=0",
               rise_edge, rise_cnt, fall_cnt, S + 3);
    end
  endtask

  task automatic test_clean_release();
    int fall_edge = -1;
    int fall_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({btn_level, btn_rise, btn_fall, btn_long} !== {m_level, e_rise, e_fall, e_long}) begin
        failures++;
        $display("FAIL clean_release edge=%0d got=%b exp=%b", i,
                 {btn_level, btn_rise, btn_fall, btn_long}, {m_level, e_rise, e_fall, e_long});
      end
      if (btn_fall) begin
        fall_cnt++;
        fall_edge = i;
        checks++;
        if (btn_level !== 1'b0) begin
          failures++;
          $display("FAIL release_level got=%b exp=0", btn_level);
        end
      end
    end
    checks++;
    if (fall_edge != S + 3 || fall_cnt != 1) begin
      failures++;
      $display("FAIL clean_release_latency fall_edge=%0d falls=%0d exp edge=%0d falls=1",
               fall_edge, fall_cnt, S + 3);
    end
  endtask

  task automatic test_bounce();
    logic pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int events = 0;
    for (int i = 0; i < 16; i++) begin
      step((i < 6) ? pat[i] : 1'b0, 1'b0);
      checks++;
      if ({btn_level, btn_rise, btn_fall, btn_long} !== {m_level, e_rise, e_fall, e_long}) begin
        failures++;
        $display("FAIL bounce cyc=%0d got=%b exp=%b", i,
                 {btn_level, btn_rise, btn_fall, btn_long}, {m_level, e_rise, e_fall, e_long});
      end
      events += int'(btn_level) + int'(btn_rise) + int'(btn_fall) + int'(btn_long);
    end
    checks++;
    if (events != 0) begin
      failures++;
      $display("FAIL bounce_events got=%0d exp=0", events);
    end
  endtask

  task automatic test_reset_mid_qual();
    int pulses = 0;
    int rise_edge = -1;
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0);
      pulses += int'(btn_rise) + int'(btn_fall) + int'(btn_level);
    end
    step(1'b1, 1'b1);
    pulses += int'(btn_rise) + int'(btn_fall) + int'(btn_level);
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_mid_qual_pre got=%0d pulses exp=0", pulses);
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if ({btn_level, btn_rise, btn_fall, btn_long} !== {m_level, e_rise, e_fall, e_long}) begin
        failures++;
        $display("FAIL reset_mid_qual edge=%0d got=%b exp=%b", i,
                 {btn_level, btn_rise, btn_fall, btn_long}, {m_level, e_rise, e_fall, e_long});
      end
      if (btn_rise) rise_edge = i;
    end
    checks++;
    if (rise_edge != S + 3) begin
      failures++;
      $display("FAIL reset_mid_qual_latency got=%0d exp=%0d", rise_edge, S + 3);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
  endtask

  // Covers both the clean long press (glitch_at < 0) and a two-cycle
  // release glitch injected glitch_at edges after the rise.
  task automatic test_long_press(input int glitch_at, input string name);
    int rise_edge = -1;
    int long_edge = -1;
    int long_cnt = 0;
    int fall_cnt = 0;
    logic b;
    step(1'b0, 1'b1);
    for (int i = 1; i <= 30; i++) begin
      b = 1'b1;
      if (glitch_at >= 0 && rise_edge > 0 &&
          (i == rise_edge + glitch_at + 1 || i == rise_edge + glitch_at + 2)) b = 1'b0;
      step(b, 1'b0);
      checks++;
      if ({btn_level, btn_rise, btn_fall, btn_long} !== {m_level, e_rise, e_fall, e_long}) begin
        failures++;
        $display("FAIL %s edge=%0d got=%b exp=%b", name, i,
                 {btn_level, btn_rise, btn_fall, btn_long}, {m_level, e_rise, e_fall, e_long});
      end
      if (btn_rise) rise_edge = i;
      if (btn_long) begin long_edge = i; long_cnt++; end
      if (btn_fall) fall_cnt++;
    end
    checks++;
    if (long_cnt != int'(LONG_EN) || fall_cnt != 0) begin
      failures++;
      $display("FAIL %s_count longs=%0d falls=%0d exp longs=%0d falls=0",
               name, long_cnt, fall_cnt, int'(LONG_EN));
    end
    if (long_cnt == 1) begin
      checks++;
      if (long_edge - rise_edge != H) begin
        failures++;
        $display("FAIL %s_delay got=%0d exp=%0d", name, long_edge - rise_edge, H);
      end
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_random();
    int run;
    logic b;
    logic r;
    for (int k = 0; k < 400; k++) begin
      b   = 1'($urandom_range(1));
      r   = ($urandom_range(99) == 0);
      run = (($urandom_range(3) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 6));
      for (int i = 0; i < run; i++) begin
        step(b, (i == 0) ? r : 1'b0);
        checks++;
        if ({btn_level, btn_rise, btn_fall, btn_long} !== {m_level, e_rise, e_fall, e_long}) begin
          failures++;
          $display("FAIL random k=%0d i=%0d got=%b exp=%b", k, i,
                   {btn_level, btn_rise, btn_fall, btn_long}, {m_level, e_rise, e_fall, e_long});
        end
        checks++;
        if ($countones({btn_rise, btn_fall, btn_long}) > 1) begin
          failures++;
          $display("FAIL random_exclusive got=%b exp=at most one pulse",
                   {btn_rise, btn_fall, btn_long});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_clean_release();
    test_bounce();
    test_reset_mid_qual();
    test_long_press(-1, "long_press");
    test_long_press(5, "hold_glitch");
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
